// File: rtl/systolic_array_ctrl.sv
// Controller for a 3-slice weight-stationary systolic dot-product array.
// Optional result counter port is enabled with SYSTOLIC_CTRL_COUNT_EN.
module systolic_array_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic signed [WIDTH-1:0]   cfg_w1,
  input  logic signed [WIDTH-1:0]   cfg_w2,
  input  logic signed [WIDTH-1:0]   cfg_w3,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH-1:0]   in_x1,
  input  logic signed [WIDTH-1:0]   in_x2,
  input  logic signed [WIDTH-1:0]   in_x3,
  output logic signed [WIDTH-1:0]   w1,
  output logic signed [WIDTH-1:0]   w2,
  output logic signed [WIDTH-1:0]   w3,
  output logic signed [WIDTH-1:0]   x1,
  output logic signed [WIDTH-1:0]   x2,
  output logic signed [WIDTH-1:0]   x3,
  output logic                      en1,
  output logic                      en2,
  output logic                      en3,
  output logic signed [2*WIDTH-1:0] yin,
  input  logic signed [2*WIDTH-1:0] arr_y,
  output logic signed [2*WIDTH-1:0] out_y,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef SYSTOLIC_CTRL_COUNT_EN
  ,
  output logic [15:0]               result_count
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  state_t                  state;
  logic                    run;
  logic signed [WIDTH-1:0] pend_w1, pend_w2, pend_w3;
  logic signed [WIDTH-1:0] x3_p0;
  logic                    vld_p0, vld_p1, vld_p2;
  logic                    stall, accept, empty;

  assign stall     = vld_p2 & ~out_ready;
  assign in_ready  = run & ~stall;
  assign accept    = in_valid & in_ready;
  assign empty     = ~(vld_p0 | vld_p1 | vld_p2);
  assign out_valid = vld_p2;
  assign yin       = '0;

  // Slice 1 sees the accepted element in the acceptance cycle itself.
  assign x1  = accept ? in_x1 : '0;
  assign en1 = accept;
  assign en2 = vld_p0 & ~stall;
  assign en3 = vld_p1 & ~stall;

  // The array is frozen while stalled, so arr_y holds the pending result.
  assign out_y = vld_p2 ? arr_y : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cfg_ready <= 1'b1;
      run       <= 1'b0;
      w1        <= '0;
      w2        <= '0;
      w3        <= '0;
      pend_w1   <= '0;
      pend_w2   <= '0;
      pend_w3   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_valid && cfg_ready) begin
            w1        <= cfg_w1;
            w2        <= cfg_w2;
            w3        <= cfg_w3;
            state     <= LOAD;
            cfg_ready <= 1'b0;
            run       <= 1'b0;
          end
        end
        LOAD: begin
          state     <= RUN;
          cfg_ready <= 1'b1;
          run       <= 1'b1;
        end
        RUN: begin
          // New weights wait until every in-flight vector has left the array.
          if (cfg_valid && cfg_ready) begin
            pend_w1   <= cfg_w1;
            pend_w2   <= cfg_w2;
            pend_w3   <= cfg_w3;
            state     <= DRAIN;
            cfg_ready <= 1'b0;
            run       <= 1'b0;
          end
        end
        DRAIN: begin
          if (empty) begin
            w1    <= pend_w1;
            w2    <= pend_w2;
            w3    <= pend_w3;
            state <= LOAD;
          end
        end
        default: begin
          state     <= IDLE;
          cfg_ready <= 1'b1;
          run       <= 1'b0;
        end
      endcase
    end
  end

  // Stage boundaries: p0 -> slice 2 operand, p1 -> slice 3 operand, p2 -> output.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      x2     <= '0;
      x3_p0  <= '0;
      x3     <= '0;
    end else if (!stall) begin
      vld_p0 <= accept;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      x2     <= accept ? in_x2 : '0;
      x3_p0  <= accept ? in_x3 : '0;
      x3     <= x3_p0;
    end
  end

`ifdef SYSTOLIC_CTRL_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      result_count <= '0;
    end else if (out_valid && out_ready) begin
      result_count <= result_count + 16'd1;
    end
  end
`endif

endmodule
